// File: rtl/bus_responder.sv
// Board-level bus responder: word RAM behind a rw/addr/data/lock bus with programmable wait states.
// Optional write protection above PROTECT_BASE is enabled by defining BUS_RESPONDER_WRITE_PROTECT_EN.
module bus_responder #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned WAIT_STATES  = 1,
    parameter logic [15:0] PROTECT_BASE = 16'h0380
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        i_rw,
    input  logic [15:0] i_addr,
    inout  wire  [15:0] io_data,
    inout  wire         io_lock,
    output logic        o_busy,
    output logic        o_err
);

    localparam int unsigned DEPTH     = 32'd1 << ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH = 4;
    localparam logic [CNT_WIDTH-1:0] WS_LOAD =
        (WAIT_STATES > 0) ? CNT_WIDTH'(WAIT_STATES - 1) : '0;

`ifdef BUS_RESPONDER_WRITE_PROTECT_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [15:0]           a_q, a_d;
    logic                  rw_q, rw_d;
    logic [15:0]           rd_q, rd_d;
    logic                  lock_en_q, lock_en_d;
    logic                  data_en_q, data_en_d;
    logic                  busy_d, err_d;

    logic [15:0] mem [DEPTH];

    logic        capture_c;
    logic [15:0] acc_addr_c;
    logic        acc_rw_c;
    logic        acc_bad_c;
    logic        wr_en_c;

    // Any address bit at or above ADDR_WIDTH makes the access out of range (no aliasing).
    function automatic logic out_of_range(input logic [15:0] a);
        return (32'(a) >> ADDR_WIDTH) != 32'd0;
    endfunction

    function automatic logic is_protected(input logic rw, input logic [15:0] a);
        return WP_EN && rw && !out_of_range(a) && (a >= PROTECT_BASE);
    endfunction

    // The address/direction the next XFER will use: fresh bus values when capturing, else latched.
    always_comb begin
        capture_c  = (state_q == IDLE) && !io_lock;
        acc_addr_c = capture_c ? i_addr : a_q;
        acc_rw_c   = capture_c ? i_rw   : rw_q;
        acc_bad_c  = out_of_range(acc_addr_c) || is_protected(acc_rw_c, acc_addr_c);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        rw_d      = rw_q;
        rd_d      = rd_q;
        lock_en_d = 1'b0;
        data_en_d = 1'b0;
        busy_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (capture_c) begin
                    a_d  = i_addr;
                    rw_d = i_rw;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = XFER;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = XFER;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            XFER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Read data is fetched on the edge that enters XFER so it is valid for the whole cycle.
        if ((state_d == XFER) && (state_q != XFER)) begin
            rd_d      = out_of_range(acc_addr_c) ? 16'h0000 : mem[acc_addr_c[ADDR_WIDTH-1:0]];
            data_en_d = !acc_rw_c;
            err_d     = acc_bad_c;
        end

        lock_en_d = (state_d == WAIT);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            rw_q      <= 1'b0;
            rd_q      <= '0;
            lock_en_q <= 1'b0;
            data_en_q <= 1'b0;
            o_busy    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            rw_q      <= rw_d;
            rd_q      <= rd_d;
            lock_en_q <= lock_en_d;
            data_en_q <= data_en_d;
            o_busy    <= busy_d;
            o_err     <= err_d;
        end
    end

    // Write commits on the edge leaving XFER; reset forces IDLE so an in-flight write is dropped.
    assign wr_en_c = (state_q == XFER) && rw_q && !out_of_range(a_q) && !is_protected(rw_q, a_q);

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[a_q[ADDR_WIDTH-1:0]] <= io_data;
        end
    end

    assign io_data = data_en_q ? rd_q : {16{1'bz}};
    assign io_lock = lock_en_q ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: two instances (1 wait state and 0 wait states) against
// a transaction-level bus/memory model, plus directed literal checks.
module tb_bus_responder;

    typedef struct packed {
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wd;
    } req_t;

`ifdef BUS_RESPONDER_WRITE_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    logic        rw_v     [2] = '{1'b0, 1'b0};
    logic [15:0] addr_v   [2] = '{16'h0, 16'h0};
    logic        ext_lock [2] = '{1'b0, 1'b0};
    logic        den      [2] = '{1'b0, 1'b0};
    logic [15:0] dval     [2] = '{16'h0, 16'h0};

    wire [15:0] data0, data1;
    wire        lock0, lock1;
    logic       busy0, busy1, err0, err1;

    assign data0 = den[0] ? dval[0] : 16'hzzzz;
    assign data1 = den[1] ? dval[1] : 16'hzzzz;
    assign lock0 = ext_lock[0] ? 1'b1 : 1'bz;
    assign lock1 = ext_lock[1] ? 1'b1 : 1'bz;
    pulldown (lock0);
    pulldown (lock1);

    bus_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1), .PROTECT_BASE(16'h0380)) u_ws1 (
        .clk(clk), .n_rst(n_rst), .i_rw(rw_v[0]), .i_addr(addr_v[0]),
        .io_data(data0), .io_lock(lock0), .o_busy(busy0), .o_err(err0)
    );

    bus_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .PROTECT_BASE(16'h0380)) u_ws0 (
        .clk(clk), .n_rst(n_rst), .i_rw(rw_v[1]), .i_addr(addr_v[1]),
        .io_data(data1), .io_lock(lock1), .o_busy(busy1), .o_err(err1)
    );

    int checks = 0;
    int errors = 0;

    // Transaction model state
    req_t        rq0[$], rq1[$];
    int          rp       [2] = '{0, 0};
    bit          m_busy   [2];
    bit          m_rw     [2];
    logic [15:0] m_addr   [2];
    logic [15:0] m_wd     [2];
    int          m_off    [2];
    bit          m_real   [2];
    bit          presented[2];
    logic [15:0] mmem [int];

    // Observations made by the compare process
    int          acc_lock [2], acc_busy [2], last_lock [2], last_busy [2];
    int          tot_lock [2], tot_err [2];
    logic [15:0] last_rd  [2];

    function automatic int ws(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic bit oor(input logic [15:0] a);
        return a >= 16'h0400;
    endfunction

    function automatic bit bad(input bit rw, input logic [15:0] a);
        return oor(a) || (PROT && rw && (a >= 16'h0380));
    endfunction

    function automatic int key(input int i, input logic [15:0] a);
        return i * 65536 + int'(a);
    endfunction

    function automatic int pending(input int i);
        return (i == 0) ? rq0.size() - rp[0] : rq1.size() - rp[1];
    endfunction

    function automatic req_t head(input int i);
        return (i == 0) ? rq0[rp[0]] : rq1[rp[1]];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model update at each edge, then the CPU side drives the bus for the coming cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!n_rst) begin
                m_busy[i] = 1'b0;
            end else if (m_busy[i]) begin
                if (m_off[i] == ws(i)) begin
                    if (m_rw[i] && !bad(1'b1, m_addr[i])) mmem[key(i, m_addr[i])] = m_wd[i];
                    m_busy[i] = 1'b0;
                end else begin
                    m_off[i]++;
                end
            end else if (!ext_lock[i]) begin
                m_busy[i] = 1'b1;
                m_rw[i]   = rw_v[i];
                m_addr[i] = addr_v[i];
                m_off[i]  = 0;
                m_real[i] = presented[i];
                m_wd[i]   = presented[i] ? head(i).wd : 16'h0000;
                if (presented[i]) rp[i]++;
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            den[i]  = m_busy[i] && (m_off[i] == ws(i)) && m_rw[i];
            dval[i] = m_wd[i];
            if (m_busy[i]) begin
                rw_v[i]      = 1'($urandom);
                addr_v[i]    = 16'($urandom);
                presented[i] = 1'b0;
            end else if (pending(i) > 0) begin
                rw_v[i]      = head(i).rw;
                addr_v[i]    = head(i).addr;
                presented[i] = 1'b1;
            end else begin
                rw_v[i]      = 1'b0;
                addr_v[i]    = 16'h0000;
                presented[i] = 1'b0;
            end
        end
    end

    // Every cycle: busy, lock and err against the model; read data in read XFER cycles.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic        lk, bz, er, xfer, e_busy, e_lock, e_err;
            logic [15:0] dt;
            lk = (i == 0) ? lock0 : lock1;
            bz = (i == 0) ? busy0 : busy1;
            er = (i == 0) ? err0  : err1;
            dt = (i == 0) ? data0 : data1;
            tot_lock[i] += int'(lk);
            tot_err[i]  += int'(er);
            if (!n_rst || !m_busy[i]) begin
                xfer = 1'b0; e_busy = 1'b0; e_lock = ext_lock[i]; e_err = 1'b0;
            end else begin
                xfer   = (m_off[i] == ws(i));
                e_busy = 1'b1;
                e_lock = ext_lock[i] | !xfer;
                e_err  = xfer && bad(m_rw[i], m_addr[i]);
            end
            chk($sformatf("busy[%0d]", i), 32'(bz), 32'(e_busy));
            chk($sformatf("lock[%0d]", i), 32'(lk), 32'(e_lock));
            chk($sformatf("err[%0d]", i),  32'(er), 32'(e_err));
            if (xfer && !m_rw[i]) begin
                if (oor(m_addr[i]))
                    chk($sformatf("rdata_oor[%0d]", i), 32'(dt), 32'h0);
                else if (mmem.exists(key(i, m_addr[i])))
                    chk($sformatf("rdata[%0d] @%h", i, m_addr[i]), 32'(dt), 32'(mmem[key(i, m_addr[i])]));
                if (m_real[i]) last_rd[i] = dt;
            end
            if (n_rst && m_busy[i] && m_real[i]) begin
                if (m_off[i] == 0) begin
                    acc_lock[i] = 0;
                    acc_busy[i] = 0;
                end
                acc_lock[i] += int'(lk);
                acc_busy[i] += int'(bz);
                if (xfer) begin
                    last_lock[i] = acc_lock[i];
                    last_busy[i] = acc_busy[i];
                end
            end
        end
    end

    task automatic push(input int i, input logic rw, input logic [15:0] a, input logic [15:0] d);
        req_t r;
        r.rw = rw; r.addr = a; r.wd = d;
        if (i == 0) rq0.push_back(r); else rq1.push_back(r);
    endtask

    task automatic drain(input int i);
        int n = 0;
        while (n < 100 && (pending(i) != 0 || (m_busy[i] && m_real[i]))) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 100) chk($sformatf("drain_timeout[%0d]", i), 32'(n), 32'd0);
    endtask

    initial begin
        int          n, b, e0;
        logic [15:0] old;

        repeat (3) @(posedge clk);
        #2 n_rst = 1'b1;
        @(negedge clk);
        chk("reset_busy0", 32'(busy0), 32'd0);
        chk("reset_lock0", 32'(lock0), 32'd0);
        chk("reset_err0",  32'(err0),  32'd0);
        chk("reset_busy1", 32'(busy1), 32'd0);

        // One wait state: write then read back.
        push(0, 1'b1, 16'h0012, 16'hBEEF);
        drain(0);
        chk("ws1_write_lock_cycles", 32'(last_lock[0]), 32'd1);
        chk("ws1_write_busy_cycles", 32'(last_busy[0]), 32'd2);
        push(0, 1'b0, 16'h0012, 16'h0000);
        drain(0);
        chk("ws1_read_data", 32'(last_rd[0]), 32'hBEEF);
        chk("ws1_read_busy_cycles", 32'(last_busy[0]), 32'd2);

        // Zero wait states: alternating write/read to 1..4.
        for (int a = 1; a <= 4; a++) begin
            push(1, 1'b1, 16'(a), 16'(a * 32'h1111));
            push(1, 1'b0, 16'(a), 16'h0000);
        end
        drain(1);
        chk("ws0_read_data", 32'(last_rd[1]), 32'h4444);
        chk("ws0_busy_cycles", 32'(last_busy[1]), 32'd1);
        chk("ws0_lock_cycles", 32'(last_lock[1]), 32'd0);

        // Out of range never aliases onto word 0.
        push(0, 1'b1, 16'h0000, 16'h5A5A);
        drain(0);
        e0 = tot_err[0];
        push(0, 1'b1, 16'h0400, 16'h1234);
        drain(0);
        chk("oor_err_pulses", 32'(tot_err[0] - e0), 32'd1);
        push(0, 1'b0, 16'h0400, 16'h0000);
        drain(0);
        chk("oor_read_zero", 32'(last_rd[0]), 32'h0000);
        push(0, 1'b0, 16'h0000, 16'h0000);
        drain(0);
        chk("oor_word0_kept", 32'(last_rd[0]), 32'h5A5A);

        // External lock holds the responder in IDLE.
        push(0, 1'b1, 16'h0020, 16'h0C0C);
        drain(0);
        n = 0;
        while (m_busy[0] && n < 10) begin
            @(posedge clk); #2;
            n++;
        end
        ext_lock[0] = 1'b1;
        b = 0;
        repeat (4) begin
            @(negedge clk);
            b += int'(busy0);
        end
        chk("ext_lock_idle", 32'(b), 32'd0);
        @(posedge clk); #2 ext_lock[0] = 1'b0;

        // Reset during WAIT drops the write and the lock line at once.
        push(0, 1'b1, 16'h0020, 16'hDEAD);
        n = 0;
        while (!(m_busy[0] && m_real[0]) && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        chk("midreset_lock_before", 32'(lock0), 32'd1);
        n_rst = 1'b0;
        #1;
        chk("midreset_lock_async", 32'(lock0), 32'd0);
        chk("midreset_busy_async", 32'(busy0), 32'd0);
        repeat (2) @(posedge clk);
        #2 n_rst = 1'b1;
        push(0, 1'b0, 16'h0020, 16'h0000);
        drain(0);
        chk("midreset_write_dropped", 32'(last_rd[0]), 32'h0C0C);

        // Protect boundary.
        push(0, 1'b1, 16'h037F, 16'h7F7F);
        push(0, 1'b0, 16'h037F, 16'h0000);
        drain(0);
        chk("below_protect_commits", 32'(last_rd[0]), 32'h7F7F);
        push(0, 1'b0, 16'h0380, 16'h0000);
        drain(0);
        old = last_rd[0];
        e0  = tot_err[0];
        push(0, 1'b1, 16'h0380, 16'hAAAA);
        push(0, 1'b0, 16'h0380, 16'h0000);
        drain(0);
`ifdef BUS_RESPONDER_WRITE_PROTECT_EN
        chk("protect_err_pulses", 32'(tot_err[0] - e0), 32'd1);
        chk("protect_keeps_old", 32'(last_rd[0]), 32'(old));
`else
        chk("noprotect_err_pulses", 32'(tot_err[0] - e0), 32'd0);
        chk("noprotect_commits", 32'(last_rd[0]), 32'hAAAA);
`endif

        repeat (3) @(posedge clk);
        chk("ws0_lock_never_driven", 32'(tot_lock[1]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bus_responder.md
# bus_responder

Memory-side responder for the CPU's external bus (`rw`, 16-bit address, bidirectional 16-bit data, shared `lock` line). It sits on the board-level bus opposite the CPU top and backs the address space with on-chip word RAM. It inserts a programmable number of wait states by driving the shared lock line high, which stalls the CPU's program counter and decoder. It completes each access by driving read data onto, or committing write data from, the shared data bus.

## Interface
- `ADDR_WIDTH`, default 10: RAM depth is 2^ADDR_WIDTH 16-bit words; valid range 1..16.
- `WAIT_STATES`, default 1: lock-asserted cycles per access; range 0..15.
- `PROTECT_BASE`, default 16'h0380: first write-protected word address; used only with the macro.
- `clk` input 1: single clock; all state updates on the rising edge.
- `n_rst` input 1: asynchronous, active-low reset.
- `i_rw` input 1: bus direction from the CPU; 0 = read (responder drives data), 1 = write (CPU drives data).
- `i_addr` input 16: word address from the CPU.
- `io_data` inout 16: shared data bus; responder drives it only in XFER with latched rw = 0, otherwise high-Z.
- `io_lock` inout 1: shared lock line, pulled down on the board; responder drives it 1'b1 in WAIT, otherwise high-Z; never drives 0.
- `o_busy` output 1: high in WAIT and XFER.
- `o_err` output 1: one-cycle pulse in XFER for an out-of-range or protected access.

## Operation
- FSM states: IDLE, WAIT, XFER.
- **IDLE**
  - Outputs: `io_data` Z, `io_lock` Z, `o_busy` 0.
  - On a rising edge with `io_lock` sampled 0, latch `i_addr` → `a_q` and `i_rw` → `rw_q`.
  - Next state is WAIT if WAIT_STATES > 0, else XFER.
  - If `io_lock` is sampled 1 (CPU or another agent holds the bus), stay in IDLE and latch nothing.
- **WAIT**
  - Drive `io_lock` = 1.
  - A 4-bit counter loads WAIT_STATES-1 on entry and decrements each cycle.
  - When the counter is 0, next state is XFER.
  - Write data is not sampled in WAIT.
- **XFER**, lasting exactly one cycle:
  - `io_lock` is Z.
  - Read (`rw_q` = 0): drive `io_data` with `rd_q`, which was loaded from `mem[a_q]` on the edge entering XFER.
  - Write (`rw_q` = 1): `mem[a_q] <= io_data` on the edge leaving XFER.
  - Next state is IDLE.
- **Range check:** if `a_q[15:ADDR_WIDTH]` != 0, the access is out of range.
  - Read returns 16'h0000; write is discarded.
  - `o_err` = 1 in XFER.
  - Addresses never alias.
- **Reset**
  - Asserting `n_rst` forces IDLE immediately.
  - `io_data` and `io_lock` go Z; `o_busy` = 0, `o_err` = 0; the counter and `a_q`/`rw_q`/`rd_q` clear to 0.
  - An in-flight write is dropped; RAM contents are not cleared.
- **`i_rw` and `i_addr` changes** in WAIT or XFER are ignored; only the latched values are used.

## Timing
- Access period is WAIT_STATES + 2 cycles: capture edge, WAIT_STATES cycles, one XFER cycle, then back in IDLE ready to capture on the next edge.
- `io_lock` rises in the cycle after the capture edge and is high for exactly WAIT_STATES cycles.
- Read data is valid on `io_data` for the whole XFER cycle. The CPU samples it on the edge ending XFER.
- Write data must be stable on `io_data` at the edge ending XFER.
- WAIT_STATES = 0: the lock line is never driven; the period is 2 cycles.
- Back-to-back accesses alternate IDLE/XFER (plus WAIT); there is no pipelining.
- Simultaneous reset and capture edge: reset wins; nothing is latched.

## Configuration
- `BUS_RESPONDER_WRITE_PROTECT_EN`
- **Defined:** a write with `a_q` >= PROTECT_BASE, and in range, is discarded and pulses `o_err` in XFER. Reads of that region are unaffected.
- **Undefined:** PROTECT_BASE is ignored, all in-range writes commit, and `o_err` reports only out-of-range accesses.

## Test plan
- **Reset:** hold `n_rst` = 0 for 3 cycles, release, with `io_lock` externally Z.
  - After release: FSM in IDLE, `io_data` = Z, `io_lock` reads 0 via the pulldown, `o_busy` = 0, `o_err` = 0.
- **Write then read,** WAIT_STATES = 1:
  - Write 16'hBEEF to 16'h0012: lock high for exactly 1 cycle, XFER on cycle 2.
  - Then read 16'h0012: `io_data` = 16'hBEEF in XFER, period 3 cycles.
- **WAIT_STATES = 0:** alternating read/write to 16'h0001..16'h0004.
  - `io_lock` is never driven; every access completes in 2 cycles; read-back matches.
- **Out of range,** ADDR_WIDTH = 10:
  - Write 16'h1234 to 16'h0400: `o_err` pulses once.
  - Read 16'h0400 returns 16'h0000; 16'h0000 is unchanged.
- **External lock and mid-access reset:**
  - Bench drives `io_lock` = 1 for 4 cycles: responder stays in IDLE.
  - Release the lock, start a write to 16'h0020, assert `n_rst` in WAIT: lock drops asynchronously and `mem[16'h0020]` keeps its prior value.
- **Protect,** macro defined and PROTECT_BASE = 16'h0380:
  - Write 16'hAAAA to 16'h0380: `o_err` = 1, and a read returns the old value.
  - Write to 16'h037F: commits.
